multicycle_controller: RTL and testbench

//  Control FSM for the 8-bit multicycle accumulator datapath; the producer side of the ALU's aluOp interface.

---
 rtl/multicycle_controller.sv | 152 +++++++++++++++
 tb/tb_multicycle_controller.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Control FSM for the 8-bit multicycle accumulator datapath: sequences fetch/decode/memory/execute,
// drives every datapath enable, mux select and aluOp, and counts retired instructions.
module multicycle_controller #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [7:0]       inst,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             addr_src,
  output logic             ir_we,
  output logic             mdr_we,
  output logic             pc_we,
  output logic             pc_src,
  output logic             alu_a_src,
  output logic             alu_b_src,
  output logic [1:0]       aluOp,
  output logic             acc_we,
  output logic             acc_src,
  output logic             busy,
  output logic [CNT_W-1:0] retired
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_MEM_RD = 3'd3;
  localparam logic [2:0] S_EXEC   = 3'd4;
  localparam logic [2:0] S_MEM_WR = 3'd5;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_AND   = 3'b010;
  localparam logic [2:0] OP_NOT   = 3'b011;
  localparam logic [2:0] OP_LOAD  = 3'b100;
  localparam logic [2:0] OP_STORE = 3'b101;
  localparam logic [2:0] OP_JMP   = 3'b110;
  localparam logic [2:0] OP_JZ    = 3'b111;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic [2:0]       opcode;
  logic             retire;
  logic             go_fetch;

  assign opcode = inst[7:5];

  always_comb begin
    state_d   = state_q;
    retire    = 1'b0;
    go_fetch  = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    addr_src  = 1'b0;
    ir_we     = 1'b0;
    mdr_we    = 1'b0;
    pc_we     = 1'b0;
    pc_src    = 1'b0;
    alu_a_src = 1'b0;
    alu_b_src = 1'b0;
    aluOp     = 2'b00;
    acc_we    = 1'b0;
    acc_src   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        mem_rd = 1'b1;
        if (mem_ready) begin
          // IR load and PC+1 happen together in the ready cycle
          ir_we     = 1'b1;
          pc_we     = 1'b1;
          alu_a_src = 1'b1;
          alu_b_src = 1'b1;
          state_d   = S_DECODE;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_NOT:   state_d = S_EXEC;
          OP_STORE: state_d = S_MEM_WR;
          OP_JMP: begin
            pc_we    = 1'b1;
            pc_src   = 1'b1;
            retire   = 1'b1;
            go_fetch = 1'b1;
          end
          OP_JZ: begin
            pc_we    = zero;
            pc_src   = 1'b1;
            retire   = 1'b1;
            go_fetch = 1'b1;
          end
          default:  state_d = S_MEM_RD;
        endcase
      end
      S_MEM_RD: begin
        mem_rd   = 1'b1;
        addr_src = 1'b1;
        if (mem_ready) begin
          mdr_we  = 1'b1;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        acc_we   = 1'b1;
        retire   = 1'b1;
        go_fetch = 1'b1;
        case (opcode)
          OP_ADD:  aluOp = 2'b00;
          OP_SUB:  aluOp = 2'b01;
          OP_AND:  aluOp = 2'b10;
          OP_NOT:  aluOp = 2'b11;
          OP_LOAD: acc_src = 1'b1;
          default: ;
        endcase
      end
      S_MEM_WR: begin
        mem_wr   = 1'b1;
        addr_src = 1'b1;
        if (mem_ready) begin
          retire   = 1'b1;
          go_fetch = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // stop only takes effect at an instruction boundary
    if (go_fetch) state_d = stop ? S_IDLE : S_FETCH;
    retired_d = retire ? retired_q + 1'b1 : retired_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle expected control vectors go through a scoreboard queue.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst_n, start, stop, zero, mem_ready;
  logic [7:0] inst;
  logic       mem_rd, mem_wr, addr_src, ir_we, mdr_we, pc_we, pc_src;
  logic       alu_a_src, alu_b_src, acc_we, acc_src, busy;
  logic [1:0] aluOp;
  logic [7:0] retired;
  logic [13:0] outs;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [7:0]  ret_m = '0;
  logic [13:0] exp_q[$];

  always #5 clk = ~clk;

  multicycle_controller #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .inst(inst), .zero(zero),
    .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_wr(mem_wr), .addr_src(addr_src),
    .ir_we(ir_we), .mdr_we(mdr_we), .pc_we(pc_we), .pc_src(pc_src),
    .alu_a_src(alu_a_src), .alu_b_src(alu_b_src), .aluOp(aluOp), .acc_we(acc_we),
    .acc_src(acc_src), .busy(busy), .retired(retired)
  );

  assign outs = {busy, mem_rd, mem_wr, addr_src, ir_we, mdr_we, pc_we, pc_src,
                 alu_a_src, alu_b_src, aluOp, acc_we, acc_src};

  // Expected control vector for a phase: 0 idle, 1 fetch, 2 decode, 3 mem_rd, 4 exec, 5 mem_wr
  function automatic logic [13:0] ex(int ph, logic [2:0] op, logic z, logic r);
    logic b, rd, wr, as, ir, mdr, pc, pcs, aa, ab, acc, accs;
    logic [1:0] ao;
    {rd, wr, as, ir, mdr, pc, pcs, aa, ab, acc, accs} = '0;
    ao = 2'b00;
    b  = (ph != 0);
    case (ph)
      1: begin rd = 1'b1; if (r) {ir, pc, aa, ab} = 4'b1111; end
      2: begin
        if (op == 3'b110) begin pc = 1'b1; pcs = 1'b1; end
        if (op == 3'b111) begin pc = z;    pcs = 1'b1; end
      end
      3: begin rd = 1'b1; as = 1'b1; mdr = r; end
      4: begin
        acc = 1'b1;
        if (op < 3'd4) ao = op[1:0];
        if (op == 3'b100) accs = 1'b1;
      end
      5: begin wr = 1'b1; as = 1'b1; end
      default: ;
    endcase
    return {b, rd, wr, as, ir, mdr, pc, pcs, aa, ab, ao, acc, accs};
  endfunction

  task automatic check_ret(input string tag);
    checks++;
    assert (retired === ret_m) else begin
      errors++;
      $error("FAIL %s retired got=%0d exp=%0d", tag, retired, ret_m);
    end
  endtask

  // Called just after a rising edge; drives mem_ready, checks at the falling edge.
  task automatic do_cycle(input logic rdy, input logic [13:0] e, input string tag);
    logic [13:0] want;
    mem_ready = rdy;
    exp_q.push_back(e);
    @(negedge clk);
    want = exp_q.pop_front();
    checks++;
    assert (outs === want) else begin
      errors++;
      $error("FAIL %s outs got=%b exp=%b", tag, outs, want);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input logic [7:0] ins, input int fw, input int mw, input logic z,
                       input bit stop_mid, input string tag);
    logic [2:0] op;
    op   = ins[7:5];
    inst = ins;
    zero = z;
    for (int i = 0; i < fw; i++) do_cycle(1'b0, ex(1, op, z, 1'b0), {tag, "_fetch_wait"});
    do_cycle(1'b1, ex(1, op, z, 1'b1), {tag, "_fetch"});
    do_cycle(1'b1, ex(2, op, z, 1'b1), {tag, "_decode"});
    if (op == 3'b011) begin
      do_cycle(1'b0, ex(4, op, z, 1'b0), {tag, "_exec"});
    end else if (op == 3'b101) begin
      for (int i = 0; i < mw; i++) do_cycle(1'b0, ex(5, op, z, 1'b0), {tag, "_memwr_wait"});
      do_cycle(1'b1, ex(5, op, z, 1'b1), {tag, "_memwr"});
    end else if (op != 3'b110 && op != 3'b111) begin
      if (stop_mid) stop = 1'b1;
      for (int i = 0; i < mw; i++) do_cycle(1'b0, ex(3, op, z, 1'b0), {tag, "_memrd_wait"});
      do_cycle(1'b1, ex(3, op, z, 1'b1), {tag, "_memrd"});
      do_cycle(1'b1, ex(4, op, z, 1'b1), {tag, "_exec"});
    end
    ret_m++;
    check_ret({tag, "_retired"});
  endtask

  task automatic do_reset_start();
    rst_n = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    ret_m = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    assert (outs === 14'b0) else begin
      errors++;
      $error("FAIL reset_outs got=%b exp=%b", outs, 14'b0);
    end
    check_ret("reset_retired");
    rst_n = 1'b1;
    do_cycle(1'b1, ex(0, 3'b000, 1'b0, 1'b1), "idle_ready_ignored");
    start = 1'b1;
    do_cycle(1'b0, ex(0, 3'b000, 1'b0, 1'b0), "idle_start");
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; zero = 1'b0; mem_ready = 1'b0; inst = '0;
    #1;
    do_reset_start();
    instr(8'b000_00011, 0, 0, 1'b0, 1'b0, "add");
    instr(8'b001_00100, 0, 3, 1'b0, 1'b0, "sub_wait3");
    instr(8'b111_00101, 0, 0, 1'b1, 1'b0, "jz_taken");
    instr(8'b111_00101, 0, 0, 1'b0, 1'b0, "jz_not_taken");
    instr(8'b101_01111, 0, 2, 1'b0, 1'b0, "store_wait2");
    instr(8'b110_00001, 0, 0, 1'b1, 1'b0, "jmp");
    instr(8'b010_00110, 2, 1, 1'b0, 1'b0, "and_fetch_wait2");
    instr(8'b100_01000, 0, 0, 1'b0, 1'b0, "load");
    instr(8'b011_00000, 1, 0, 1'b0, 1'b0, "not");

    // 256 NOTs from a fresh reset: counter must come back around to 0
    do_reset_start();
    for (int i = 0; i < 256; i++) instr(8'b011_00000, 0, 0, 1'b0, 1'b0, "not_wrap");
    checks++;
    assert (retired === 8'd0) else begin
      errors++;
      $error("FAIL wrap_to_zero retired got=%0d exp=0", retired);
    end

    instr(8'b100_00010, 0, 1, 1'b0, 1'b1, "load_stop");
    do_cycle(1'b1, ex(0, 3'b000, 1'b0, 1'b1), "stop_idle");
    do_cycle(1'b0, ex(0, 3'b000, 1'b0, 1'b0), "stop_idle_hold");
    stop = 1'b0;

    start = 1'b1;
    do_cycle(1'b0, ex(0, 3'b000, 1'b0, 1'b0), "restart_idle");
    start = 1'b0;
    do_cycle(1'b0, ex(1, 3'b000, 1'b0, 1'b0), "fetch_before_rst");
    rst_n = 1'b0;
    #1;
    checks++;
    assert (outs === 14'b0) else begin
      errors++;
      $error("FAIL rst_mid_fetch_outs got=%b exp=%b", outs, 14'b0);
    end
    ret_m = '0;
    check_ret("rst_mid_fetch_retired");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
